// File: rtl/tmr_scrubber_pkg.sv
// Shared definitions for the triplicated register bank and its background scrubber:
// scrubber FSM encoding, default replica width and a lane-flag counting helper.
package tmr_scrubber_pkg;

    localparam int TMR_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_VOTE  = 3'd2,
        ST_WRITE = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Number of replicas that disagree with the voted word (0..3).
    function automatic logic [1:0] lane_errs(input logic e_a, input logic e_b, input logic e_c);
        return {1'b0, e_a} + {1'b0, e_b} + {1'b0, e_c};
    endfunction

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter with per-lane disagreement flags; shared with the
// register bank read path.
module tmr_vote
    import tmr_scrubber_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] v,
    output logic         e_a,
    output logic         e_b,
    output logic         e_c
);

    assign v   = (a & b) | (b & c) | (a & c);
    assign e_a = |(a ^ v);
    assign e_b = |(b ^ v);
    assign e_c = |(c ^ v);

endmodule

// File: rtl/tmr_scrubber.sv
// Background scrubber: sweeps the triplicated bank, votes each word, writes back
// corrected words and counts single- and multi-lane upsets.
module tmr_scrubber
    import tmr_scrubber_pkg::*;
#(
    parameter int W     = TMR_W,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    input  logic [W-1:0]     rd_a,
    input  logic [W-1:0]     rd_b,
    input  logic [W-1:0]     rd_c,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [W-1:0]     wr_data,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] multi_cnt,
    input  logic             clr_cnt
);

    localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    state_t           state_r, state_s;
    logic [AW-1:0]    addr_r, addr_s;
    logic             stop_r;
    logic [CNT_W-1:0] corr_cnt_r, corr_s;
    logic [CNT_W-1:0] multi_cnt_r, multi_s;
    logic             busy_r, done_r, rd_en_r, wr_en_r;
    logic [AW-1:0]    rd_addr_r, wr_addr_r;
    logic [W-1:0]     wr_data_r;
    logic [W-1:0]     vote_s;
    logic             e_a_s, e_b_s, e_c_s;
    logic [1:0]       n_err_s;
    logic             mismatch_s;

    tmr_vote #(.W(W)) u_vote (
        .a   (rd_a),
        .b   (rd_b),
        .c   (rd_c),
        .v   (vote_s),
        .e_a (e_a_s),
        .e_b (e_b_s),
        .e_c (e_c_s)
    );

    assign n_err_s    = lane_errs(e_a_s, e_b_s, e_c_s);
    assign mismatch_s = (n_err_s != 2'd0);

    // Next state and word address; the last word always completes the sweep even if stop is pending.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_READ;
                    addr_s  = {AW{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ:  state_s = ST_VOTE;
            ST_VOTE:  state_s = mismatch_s ? ST_WRITE : ST_NEXT;
            ST_WRITE: state_s = ST_NEXT;
            ST_NEXT: begin
                if (addr_r == LAST_ADDR) begin
                    state_s = ST_DONE;
                end else if (stop_r || stop) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_READ;
                    addr_s  = addr_r + AW'(1);
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Saturating upset counters; a clear wins over a same-cycle increment.
    always_comb begin
        corr_s  = corr_cnt_r;
        multi_s = multi_cnt_r;
        if (clr_cnt) begin
            corr_s  = CNT_ZERO;
            multi_s = CNT_ZERO;
        end else if (state_r == ST_VOTE) begin
            if (n_err_s == 2'd1) begin
                corr_s = (corr_cnt_r != CNT_MAX) ? corr_cnt_r + CNT_W'(1) : corr_cnt_r;
            end else if (n_err_s >= 2'd2) begin
                multi_s = (multi_cnt_r != CNT_MAX) ? multi_cnt_r + CNT_W'(1) : multi_cnt_r;
            end else begin
                corr_s = corr_cnt_r;
            end
        end else begin
            corr_s = corr_cnt_r;
        end
    end

    // Control state, stop latch and counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            addr_r      <= {AW{1'b0}};
            stop_r      <= 1'b0;
            corr_cnt_r  <= CNT_ZERO;
            multi_cnt_r <= CNT_ZERO;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            corr_cnt_r  <= corr_s;
            multi_cnt_r <= multi_s;
            if (state_s == ST_IDLE) begin
                stop_r <= 1'b0;
            end else if (stop && (state_r != ST_IDLE)) begin
                stop_r <= 1'b1;
            end else begin
                stop_r <= stop_r;
            end
        end
    end

    // Outputs are registered from the next state so each strobe lines up with its state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rd_en_r   <= 1'b0;
            wr_en_r   <= 1'b0;
            rd_addr_r <= {AW{1'b0}};
            wr_addr_r <= {AW{1'b0}};
            wr_data_r <= {W{1'b0}};
        end else begin
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
            rd_en_r <= (state_s == ST_READ);
            wr_en_r <= (state_s == ST_WRITE);
            if (state_s == ST_READ) begin
                rd_addr_r <= addr_s;
            end else begin
                rd_addr_r <= rd_addr_r;
            end
            if (state_s == ST_WRITE) begin
                wr_addr_r <= addr_r;
                wr_data_r <= vote_s;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign rd_en     = rd_en_r;
    assign rd_addr   = rd_addr_r;
    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign corr_cnt  = corr_cnt_r;
    assign multi_cnt = multi_cnt_r;

endmodule
